riscv_issue_scoreboard: RTL and testbench
=========================================

Name: riscv_issue_scoreboard

Overview:
- Register scoreboard and issue controller at the ID/EX boundary for long-latency units: LSU loads, MUL, DIV.
- Tracks per-register pending writes and per-unit in-flight credits.
- Stalls IF/ID and inserts an EX bubble on RAW/WAW hazards or credit exhaustion.
- Generalises single-cycle load-use detection to multi-cycle, out-of-order writeback across units.

Parameters:
- LSU_DEPTH, 2, max in-flight loads.
- MUL_DEPTH, 3, max in-flight multiplies (pipelined MUL).
- DIV_DEPTH, 1, max in-flight divides (iterative DIV).
- WB_BYPASS, 1, 1 = a writeback in the same cycle satisfies a RAW hazard (WB forwarding present).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs1_addr  in  5  source 1
- id_rs2_addr  in  5  source 2
- id_rs1_used  in  1  rs1 is read
- id_rs2_used  in  1  rs2 is read
- id_rd_addr  in  5  destination
- id_rd_we  in  1  instruction writes rd
- id_unit  in  2  UNIT_ALU=0, UNIT_LSU=1, UNIT_MUL=2, UNIT_DIV=3
- redirect  in  1  branch/exception flush from EX; kills the ID instruction this cycle
- wb_valid  in  3  per-unit writeback strobe, bit0=LSU, bit1=MUL, bit2=DIV
- wb_rd_addr  in  15  per-unit writeback rd, 5 bits per unit, same bit order
- issue_fire  out  1  ID instruction issues to EX this cycle
- stall_if  out  1  hold PC/IF
- stall_id  out  1  hold ID register
- flush_ex  out  1  insert bubble into EX
- pending_vec  out  32  registered pending bits, bit0 always 0
- err_sticky  out  1  sticky protocol error

Behaviour:
- State:
  - pending[31:1] with owner[r] (2-bit unit id) per register.
  - Counters cnt_lsu/cnt_mul/cnt_div, each $clog2(DEPTH+1) bits.
  - err_sticky.
- Reset (async, rst=1): all pending=0, owner=0, counters=0, err_sticky=0. With id_valid=0 all stall/flush/fire outputs are 0. A reset mid-operation discards all tracked writes.
- Combinational hazard terms, computed from registered state plus current inputs:
  - wb_hit(r): any wb_valid[u] with wb_rd_addr[u]==r and owner[r]==u.
  - raw: (rs1_used & rs1!=0 & pending[rs1] & ~(WB_BYPASS & wb_hit(rs1))), OR the same term for rs2.
  - waw: id_rd_we & rd!=0 & pending[rd] & ~wb_hit(rd). WB_BYPASS does not apply to WAW.
  - credit: id_unit!=ALU & cnt[unit]==DEPTH[unit] & ~wb_valid[unit].
  - hazard = id_valid & (raw | waw | credit).
- Outputs:
  - stall_if = stall_id = flush_ex = hazard & ~redirect. A redirect overrides the stall.
  - issue_fire = id_valid & ~hazard & ~redirect.
- Update on posedge clk:
  - Writeback: for each u with wb_valid[u]: cnt[u] decrements. If wb_rd_addr!=0 and owner matches, pending clears.
  - Issue: on issue_fire with id_unit!=ALU, cnt[unit] increments. If also id_rd_we and rd!=0, set pending[rd] and owner[rd]=id_unit.
  - ALU instructions never touch the scoreboard; they are covered by the forwarding network.
  - Simultaneous increment and decrement on one unit leaves the counter unchanged.
  - Simultaneous set and clear of one register: the set wins and owner takes the new unit. This is reachable only via the bypassed WAW case.
  - Multiple units writing back the same rd in one cycle: only the owner clears; the other sets err_sticky.
- Errors (set err_sticky; it clears only on rst):
  - wb_valid[u] with cnt[u]==0. The counter saturates at 0.
  - Writeback rd!=0 whose pending bit is 0 or whose owner mismatches. pending is unchanged.
- Latency: hazard is a 0-cycle combinational result. The scoreboard update is visible on pending_vec 1 cycle after issue/wb. A dependent instruction issues in the same cycle as the producer's writeback when WB_BYPASS=1, else 1 cycle later.
- redirect does not clear pending; issued operations always write back.

Decomposition:
- Package riscv_pipe_pkg holds the unit_e enum (UNIT_ALU/LSU/MUL/DIV), NUM_LT_UNITS=3, and REG_ADDR_W=5.
- One sub-module, riscv_credit_counter: a parameterised up/down counter with DEPTH, full flag, and underflow error. Instantiated three times.

Test Plan:
1. Load x5 (LSU) issues; next instruction `add x6,x5,x1` → stall_if/stall_id/flush_ex=1 each cycle until wb_valid[0] with rd=5. That cycle: issue_fire=1 (WB_BYPASS=1), and pending_vec[5]=0 on the next edge.
2. Three back-to-back DIV issues with DIV_DEPTH=1 → the second DIV stalls until wb_valid[2]. In the wb cycle the second issues (credit bypass) and cnt_div stays 1.
3. MUL writes x7 while pending; a later LSU load to x7 → WAW stall until MUL wb rd=7. The load issues that cycle; owner[7]=LSU and pending_vec[7] stays 1.
4. Hazard on rs2=x9 with redirect=1 in the same cycle → stall=0, flush_ex=0, issue_fire=0, scoreboard unchanged.
5. wb_valid[1] with cnt_mul=0 → err_sticky=1 and stays 1. Then rst pulse asynchronously mid-cycle → pending_vec=0, counters 0, err_sticky=0 immediately.
6. Source or destination x0 with any pending state, e.g. `lw x0` then `add x1,x0,x0` → no stall, pending_vec[0]=0, and cnt_lsu still increments on the load.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: execution unit ids and register-file geometry.
package riscv_pipe_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned NUM_LT_UNITS = 3;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_LSU = 2'd1,
    UNIT_MUL = 2'd2,
    UNIT_DIV = 2'd3
  } unit_e;

  // Long-latency unit index (0=LSU, 1=MUL, 2=DIV) to its unit id.
  function automatic unit_e lt_unit(input int unsigned idx);
    return unit_e'(2'(idx + 1));
  endfunction

endpackage

// File: rtl/riscv_credit_counter.sv
// In-flight credit counter for one long-latency unit: up on issue, down on writeback.
module riscv_credit_counter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full_c,
  output logic underflow_c
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Issue and writeback in the same cycle cancel; both ends saturate.
  always_comb begin
    cnt_nxt = cnt;
    if (inc && !dec && (cnt != CNT_W'(DEPTH))) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign full_c      = (cnt == CNT_W'(DEPTH));
  assign underflow_c = dec && (cnt == '0);

endmodule

// File: rtl/riscv_issue_scoreboard.sv
// ID/EX issue scoreboard: tracks pending long-latency writes per register and
// per-unit credits, and stalls issue on RAW/WAW hazards or credit exhaustion.
module riscv_issue_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned LSU_DEPTH = 2,
  parameter int unsigned MUL_DEPTH = 3,
  parameter int unsigned DIV_DEPTH = 1,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_we,
  input  logic [1:0]  id_unit,
  input  logic        redirect,
  input  logic [2:0]  wb_valid,
  input  logic [14:0] wb_rd_addr,
  output logic        issue_fire,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_ex,
  output logic [31:0] pending_vec,
  output logic        err_sticky
);

  unit_e                   id_unit_e;
  logic [NUM_REGS-1:0]     pending;
  logic [NUM_REGS-1:0]     pending_nxt;
  unit_e                   owner     [NUM_REGS];
  unit_e                   owner_nxt [NUM_REGS];
  logic                    err_nxt;

  logic [REG_ADDR_W-1:0]   wb_rd     [NUM_LT_UNITS];
  logic [NUM_REGS-1:0]     wb_dec    [NUM_LT_UNITS];
  logic [NUM_LT_UNITS-1:0] wb_own;
  logic [NUM_LT_UNITS-1:0] wb_match;
  logic [NUM_LT_UNITS-1:0] wb_err;
  logic [NUM_REGS-1:0]     wb_clr;

  logic [NUM_LT_UNITS-1:0] unit_sel;
  logic [NUM_LT_UNITS-1:0] cnt_inc;
  logic [NUM_LT_UNITS-1:0] cnt_full;
  logic [NUM_LT_UNITS-1:0] cnt_uflow;

  logic raw_rs1;
  logic raw_rs2;
  logic waw;
  logic credit;
  logic hazard;

  assign id_unit_e = unit_e'(id_unit);

  // Per-unit writeback decode: a writeback only retires the register it owns.
  for (genvar u = 0; u < NUM_LT_UNITS; u++) begin : g_unit
    assign wb_rd[u]    = wb_rd_addr[u*REG_ADDR_W +: REG_ADDR_W];
    assign wb_own[u]   = pending[wb_rd[u]] && (owner[wb_rd[u]] == lt_unit(u));
    assign wb_match[u] = wb_valid[u] && (wb_rd[u] != '0) && wb_own[u];
    assign wb_err[u]   = wb_valid[u] && (wb_rd[u] != '0) && !wb_own[u];
    assign wb_dec[u]   = wb_match[u] ? (NUM_REGS'(1) << wb_rd[u]) : '0;
    assign unit_sel[u] = (id_unit_e == lt_unit(u));
    assign cnt_inc[u]  = issue_fire && unit_sel[u];
  end

  assign wb_clr = wb_dec[0] | wb_dec[1] | wb_dec[2];

  riscv_credit_counter #(.DEPTH(LSU_DEPTH)) u_cnt_lsu (
    .clk         (clk),
    .rst         (rst),
    .inc         (cnt_inc[0]),
    .dec         (wb_valid[0]),
    .full_c      (cnt_full[0]),
    .underflow_c (cnt_uflow[0])
  );

  riscv_credit_counter #(.DEPTH(MUL_DEPTH)) u_cnt_mul (
    .clk         (clk),
    .rst         (rst),
    .inc         (cnt_inc[1]),
    .dec         (wb_valid[1]),
    .full_c      (cnt_full[1]),
    .underflow_c (cnt_uflow[1])
  );

  riscv_credit_counter #(.DEPTH(DIV_DEPTH)) u_cnt_div (
    .clk         (clk),
    .rst         (rst),
    .inc         (cnt_inc[2]),
    .dec         (wb_valid[2]),
    .full_c      (cnt_full[2]),
    .underflow_c (cnt_uflow[2])
  );

  // Same-cycle writeback relieves RAW only with WB forwarding; WAW never bypasses it.
  assign raw_rs1 = id_rs1_used && (id_rs1_addr != '0) && pending[id_rs1_addr] &&
                   !(WB_BYPASS && wb_clr[id_rs1_addr]);
  assign raw_rs2 = id_rs2_used && (id_rs2_addr != '0) && pending[id_rs2_addr] &&
                   !(WB_BYPASS && wb_clr[id_rs2_addr]);
  assign waw     = id_rd_we && (id_rd_addr != '0) && pending[id_rd_addr] &&
                   !wb_clr[id_rd_addr];
  assign credit  = |(unit_sel & cnt_full & ~wb_valid);
  assign hazard  = id_valid && (raw_rs1 || raw_rs2 || waw || credit);

  assign stall_if   = hazard && !redirect;
  assign stall_id   = hazard && !redirect;
  assign flush_ex   = hazard && !redirect;
  assign issue_fire = id_valid && !hazard && !redirect;

  // Retire writebacks first so a bypassed WAW issue re-claims the register.
  always_comb begin
    pending_nxt = pending & ~wb_clr;
    owner_nxt   = owner;
    err_nxt     = err_sticky || (|cnt_uflow) || (|wb_err);
    if (issue_fire && (id_unit_e != UNIT_ALU) && id_rd_we && (id_rd_addr != '0)) begin
      pending_nxt[id_rd_addr] = 1'b1;
      owner_nxt[id_rd_addr]   = id_unit_e;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      owner      <= '{default: UNIT_ALU};
      err_sticky <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      owner      <= owner_nxt;
      err_sticky <= err_nxt;
    end
  end

  assign pending_vec = pending;

endmodule

// File: tb/tb_riscv_issue_scoreboard.sv
// Bench for riscv_issue_scoreboard: directed scenarios plus randomized traffic
// against a register/credit model of the issue rules.
module tb_riscv_issue_scoreboard;

  localparam logic [1:0] A = 2'd0;
  localparam logic [1:0] L = 2'd1;
  localparam logic [1:0] M = 2'd2;
  localparam logic [1:0] D = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd_addr;
  logic        id_rd_we;
  logic [1:0]  id_unit;
  logic        redirect;
  logic [2:0]  wb_valid;
  logic [14:0] wb_rd_addr;
  logic        issue_fire;
  logic        stall_if;
  logic        stall_id;
  logic        flush_ex;
  logic [31:0] pending_vec;
  logic        err_sticky;

  riscv_issue_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_unit(id_unit),
    .redirect(redirect), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .issue_fire(issue_fire), .stall_if(stall_if), .stall_id(stall_id),
    .flush_ex(flush_ex), .pending_vec(pending_vec), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: which register waits on which unit, and in-flight counts.
  bit m_pend [32];
  int m_own  [32];
  int m_cnt  [3];
  bit m_err;
  int depth  [3] = '{2, 3, 1};

  logic o_stall_if, o_stall_id, o_flush, o_fire, o_err;
  logic [31:0] o_pend;
  bit e_stall, e_fire, e_err;
  logic [31:0] e_pend;

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_pend[r] = 1'b0;
      m_own[r]  = 0;
    end
    for (int u = 0; u < 3; u++) m_cnt[u] = 0;
    m_err = 1'b0;
  endfunction

  function automatic bit m_hit(input int r, input logic [2:0] wbv, input int wr[3]);
    for (int u = 0; u < 3; u++)
      if (wbv[u] && wr[u] == r && m_own[r] == u + 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [14:0] wbr3(input logic [4:0] l, input logic [4:0] m, input logic [4:0] d);
    return {d, m, l};
  endfunction

  // One cycle: drive, sample combinational outputs, step model, sample state after the edge.
  task automatic apply(input bit v, input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                       input bit we, input logic [1:0] unit, input bit redir,
                       input logic [2:0] wbv, input logic [14:0] wbr);
    bit raw, waw, credit, haz, inc, dec;
    int wr[3];
    int ui;
    bit npend[32];
    int nown[32];
    @(negedge clk);
    id_valid = v; id_rs1_addr = rs1; id_rs1_used = u1; id_rs2_addr = rs2;
    id_rs2_used = u2; id_rd_addr = rd; id_rd_we = we; id_unit = unit;
    redirect = redir; wb_valid = wbv; wb_rd_addr = wbr;
    #1;
    o_stall_if = stall_if; o_stall_id = stall_id; o_flush = flush_ex; o_fire = issue_fire;
    for (int u = 0; u < 3; u++) wr[u] = int'((wbr >> (5 * u)) & 15'h1f);
    raw = (u1 && rs1 != 0 && m_pend[rs1] && !m_hit(int'(rs1), wbv, wr)) ||
          (u2 && rs2 != 0 && m_pend[rs2] && !m_hit(int'(rs2), wbv, wr));
    waw = we && rd != 0 && m_pend[rd] && !m_hit(int'(rd), wbv, wr);
    ui = int'(unit) - 1;
    credit = (unit != A) && m_cnt[ui] == depth[ui] && !wbv[ui];
    haz = v && (raw || waw || credit);
    e_stall = haz && !redir;
    e_fire  = v && !haz && !redir;
    npend = m_pend;
    nown  = m_own;
    for (int u = 0; u < 3; u++) begin
      if (wbv[u]) begin
        if (m_cnt[u] == 0) m_err = 1'b1;
        if (wr[u] != 0) begin
          if (m_pend[wr[u]] && m_own[wr[u]] == u + 1) npend[wr[u]] = 1'b0;
          else m_err = 1'b1;
        end
      end
      inc = e_fire && int'(unit) == u + 1;
      dec = wbv[u];
      if (inc && !dec) m_cnt[u] = m_cnt[u] + 1;
      else if (dec && !inc && m_cnt[u] > 0) m_cnt[u] = m_cnt[u] - 1;
    end
    if (e_fire && unit != A && we && rd != 0) begin
      npend[rd] = 1'b1;
      nown[rd]  = int'(unit);
    end
    m_pend = npend;
    m_own  = nown;
    for (int r = 0; r < 32; r++) e_pend[r] = m_pend[r];
    e_err = m_err;
    @(posedge clk);
    #1;
    o_pend = pending_vec;
    o_err  = err_sticky;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_valid = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_addr = '0; id_rd_we = 1'b0;
    id_unit = A; redirect = 1'b0; wb_valid = '0; wb_rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (pending_vec !== 32'h0) begin miscompares++; $display("FAIL reset_pending got=%h exp=0", pending_vec); end
    vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err_sticky); end
    vectors++; if ({stall_if, stall_id, flush_ex, issue_fire} !== 4'b0) begin
      miscompares++; $display("FAIL reset_ctl got=%b exp=0000", {stall_if, stall_id, flush_ex, issue_fire}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    apply(1, 0, 0, 0, 0, 5, 1, L, 0, 3'b000, '0);
    vectors++; if (o_fire !== 1'b1) begin miscompares++; $display("FAIL lu_load_fire got=%b exp=1", o_fire); end
    vectors++; if (o_pend !== 32'h20) begin miscompares++; $display("FAIL lu_pend_set got=%h exp=00000020", o_pend); end
    for (int i = 0; i < 3; i++) begin
      apply(1, 5, 1, 1, 1, 6, 1, A, 0, 3'b000, '0);
      vectors++; if ({o_stall_if, o_stall_id, o_flush, o_fire} !== 4'b1110) begin
        miscompares++; $display("FAIL lu_stall cyc=%0d got=%b exp=1110", i, {o_stall_if, o_stall_id, o_flush, o_fire}); end
    end
    apply(1, 5, 1, 1, 1, 6, 1, A, 0, 3'b001, wbr3(5, 0, 0));
    vectors++; if ({o_stall_if, o_fire} !== 2'b01) begin
      miscompares++; $display("FAIL lu_bypass_issue got=%b exp=01", {o_stall_if, o_fire}); end
    vectors++; if (o_pend !== 32'h0) begin miscompares++; $display("FAIL lu_pend_clear got=%h exp=0", o_pend); end
  endtask

  task automatic test_div_credit();
    apply(1, 0, 0, 0, 0, 10, 1, D, 0, 3'b000, '0);
    vectors++; if (o_fire !== 1'b1) begin miscompares++; $display("FAIL div1_fire got=%b exp=1", o_fire); end
    repeat (2) begin
      apply(1, 0, 0, 0, 0, 11, 1, D, 0, 3'b000, '0);
      vectors++; if ({o_stall_id, o_fire} !== 2'b10) begin
        miscompares++; $display("FAIL div2_credit_stall got=%b exp=10", {o_stall_id, o_fire}); end
    end
    apply(1, 0, 0, 0, 0, 11, 1, D, 0, 3'b100, wbr3(0, 0, 10));
    vectors++; if (o_fire !== 1'b1) begin miscompares++; $display("FAIL div2_bypass_fire got=%b exp=1", o_fire); end
    apply(1, 0, 0, 0, 0, 12, 1, D, 0, 3'b000, '0);
    vectors++; if ({o_stall_id, o_fire} !== 2'b10) begin
      miscompares++; $display("FAIL div3_stall got=%b exp=10", {o_stall_id, o_fire}); end
    apply(1, 0, 0, 0, 0, 12, 1, D, 0, 3'b100, wbr3(0, 0, 11));
    vectors++; if (o_fire !== 1'b1) begin miscompares++; $display("FAIL div3_fire got=%b exp=1", o_fire); end
    apply(0, 0, 0, 0, 0, 0, 0, A, 0, 3'b100, wbr3(0, 0, 12));
    vectors++; if ({o_pend, o_err} !== 33'h0) begin
      miscompares++; $display("FAIL div_drain got=%h/%b exp=0/0", o_pend, o_err); end
  endtask

  task automatic test_waw();
    apply(1, 0, 0, 0, 0, 7, 1, M, 0, 3'b000, '0);
    vectors++; if (o_fire !== 1'b1) begin miscompares++; $display("FAIL waw_mul_fire got=%b exp=1", o_fire); end
    repeat (2) begin
      apply(1, 0, 0, 0, 0, 7, 1, L, 0, 3'b000, '0);
      vectors++; if ({o_flush, o_fire} !== 2'b10) begin
        miscompares++; $display("FAIL waw_stall got=%b exp=10", {o_flush, o_fire}); end
    end
    apply(1, 0, 0, 0, 0, 7, 1, L, 0, 3'b010, wbr3(0, 7, 0));
    vectors++; if (o_fire !== 1'b1) begin miscompares++; $display("FAIL waw_load_fire got=%b exp=1", o_fire); end
    vectors++; if (o_pend !== 32'h80) begin miscompares++; $display("FAIL waw_pend_kept got=%h exp=00000080", o_pend); end
    apply(0, 0, 0, 0, 0, 0, 0, A, 0, 3'b001, wbr3(7, 0, 0));
    vectors++; if ({o_pend, o_err} !== 33'h0) begin
      miscompares++; $display("FAIL waw_owner_lsu got=%h/%b exp=0/0", o_pend, o_err); end
  endtask

  task automatic test_redirect();
    apply(1, 0, 0, 0, 0, 9, 1, L, 0, 3'b000, '0);
    apply(1, 0, 1, 9, 1, 1, 1, A, 1, 3'b000, '0);
    vectors++; if ({o_stall_if, o_stall_id, o_flush, o_fire} !== 4'b0000) begin
      miscompares++; $display("FAIL redir_ctl got=%b exp=0000", {o_stall_if, o_stall_id, o_flush, o_fire}); end
    vectors++; if (o_pend !== 32'h200) begin miscompares++; $display("FAIL redir_pend got=%h exp=00000200", o_pend); end
    apply(0, 0, 0, 0, 0, 0, 0, A, 0, 3'b001, wbr3(9, 0, 0));
    vectors++; if (o_pend !== 32'h0) begin miscompares++; $display("FAIL redir_drain got=%h exp=0", o_pend); end
  endtask

  task automatic test_x0();
    apply(1, 0, 0, 0, 0, 0, 1, L, 0, 3'b000, '0);
    vectors++; if ({o_fire, o_pend} !== {1'b1, 32'h0}) begin
      miscompares++; $display("FAIL x0_load got=%b/%h exp=1/0", o_fire, o_pend); end
    apply(1, 0, 1, 0, 1, 1, 1, A, 0, 3'b000, '0);
    vectors++; if ({o_stall_if, o_fire} !== 2'b01) begin
      miscompares++; $display("FAIL x0_src got=%b exp=01", {o_stall_if, o_fire}); end
    apply(1, 0, 0, 0, 0, 0, 1, L, 0, 3'b000, '0);
    apply(1, 0, 0, 0, 0, 3, 1, L, 0, 3'b000, '0);
    vectors++; if ({o_stall_if, o_fire} !== 2'b10) begin
      miscompares++; $display("FAIL x0_credit_counted got=%b exp=10", {o_stall_if, o_fire}); end
    repeat (2) apply(0, 0, 0, 0, 0, 0, 0, A, 0, 3'b001, '0);
    vectors++; if ({o_pend, o_err} !== 33'h0) begin
      miscompares++; $display("FAIL x0_drain got=%h/%b exp=0/0", o_pend, o_err); end
  endtask

  task automatic test_err_and_async_reset();
    apply(0, 0, 0, 0, 0, 0, 0, A, 0, 3'b010, '0);
    vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL err_underflow got=%b exp=1", o_err); end
    apply(0, 0, 0, 0, 0, 0, 0, A, 0, 3'b000, '0);
    vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky_hold got=%b exp=1", o_err); end
    apply(1, 0, 0, 0, 0, 3, 1, L, 0, 3'b000, '0);
    vectors++; if (o_pend !== 32'h8) begin miscompares++; $display("FAIL err_pend_x3 got=%h exp=00000008", o_pend); end
    @(negedge clk);
    id_valid = 1'b0; wb_valid = '0;
    #2 rst = 1'b1;
    #1;
    vectors++; if ({pending_vec, err_sticky} !== 33'h0) begin
      miscompares++; $display("FAIL async_rst got=%h/%b exp=0/0", pending_vec, err_sticky); end
    vectors++; if ({stall_if, flush_ex, issue_fire} !== 3'b000) begin
      miscompares++; $display("FAIL async_rst_ctl got=%b exp=000", {stall_if, flush_ex, issue_fire}); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply(1, 0, 0, 0, 0, 0, 1, L, 0, 3'b000, '0);
    apply(1, 0, 0, 0, 0, 0, 1, L, 0, 3'b000, '0);
    vectors++; if (o_fire !== 1'b1) begin miscompares++; $display("FAIL rst_cnt_clear got=%b exp=1", o_fire); end
    repeat (2) apply(0, 0, 0, 0, 0, 0, 0, A, 0, 3'b001, '0);
  endtask

  task automatic test_random();
    int q[3][$];
    bit v, u1, u2, we, redir;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] unit;
    logic [2:0] wbv;
    logic [4:0] wr[3];
    int idx;
    bit need_new = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (need_new) begin
        v    = $urandom_range(0, 99) < 85;
        rs1  = 5'($urandom_range(0, 7)); u1 = 1'($urandom);
        rs2  = 5'($urandom_range(0, 7)); u2 = 1'($urandom);
        rd   = 5'($urandom_range(0, 7)); we = $urandom_range(0, 99) < 80;
        unit = 2'($urandom_range(0, 3));
      end
      wbv = '0;
      for (int u = 0; u < 3; u++) begin
        wr[u] = '0;
        if (q[u].size() > 0 && $urandom_range(0, 99) < 35) begin
          idx = $urandom_range(0, q[u].size() - 1);
          wr[u] = 5'(q[u][idx]);
          q[u].delete(idx);
          wbv[u] = 1'b1;
        end
      end
      redir = $urandom_range(0, 99) < 5;
      apply(v, rs1, u1, rs2, u2, rd, we, unit, redir, wbv, wbr3(wr[0], wr[1], wr[2]));
      vectors++; if ({o_stall_if, o_stall_id, o_flush} !== {3{e_stall}}) begin
        miscompares++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, {o_stall_if, o_stall_id, o_flush}, {3{e_stall}}); end
      vectors++; if (o_fire !== e_fire) begin
        miscompares++; $display("FAIL rnd_fire cyc=%0d got=%b exp=%b", c, o_fire, e_fire); end
      vectors++; if (o_pend !== e_pend) begin
        miscompares++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", c, o_pend, e_pend); end
      vectors++; if (o_err !== e_err) begin
        miscompares++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, o_err, e_err); end
      if (e_fire && unit != A) q[int'(unit) - 1].push_back(we ? int'(rd) : 0);
      need_new = !v || e_fire || redir;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_div_credit();
    test_waw();
    test_redirect();
    test_x0();
    test_err_and_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
